ae18_stack_ctl: RTL

Return-stack controller for the AE18 core. It owns one `ae18_sram` instance and sequences it as a hardware call stack: push, pop, TOS overwrite and stack-pointer load. It maintains sticky full/underflow flags and an optional stack-error reset request. It sits between the core's fetch/branch logic (CALL/RETURN/PUSH/POP) and the SFR file (STKPTR/TOS access).

---
 rtl/ae18_pkg.sv | 14 +
 rtl/ae18_stack_ctl_if.sv | 30 +++
 rtl/ae18_sram.sv | 23 ++
 rtl/ae18_stack_ctl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ae18_pkg.sv
// Shared definitions for the AE18 return-stack controller.
package ae18_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } stk_state_e;

    // Highest usable stack index for a given pointer width.
    function automatic int unsigned stk_max(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/ae18_stack_ctl_if.sv
// Request/status bundle between the core/SFR logic and the stack controller.
interface ae18_stack_ctl_if #(
    parameter int DW = 21,
    parameter int AW = 5
);
    logic          push;
    logic [DW-1:0] push_dat;
    logic          pop;
    logic          tos_we;
    logic [DW-1:0] tos_wdat;
    logic          sp_we;
    logic [AW-1:0] sp_wdat;
    logic          flg_clr;
    logic [DW-1:0] tos;
    logic [AW-1:0] sp;
    logic          stkful;
    logic          stkunf;
    logic          serr_rst;
    logic          busy;

    modport master (
        output push, push_dat, pop, tos_we, tos_wdat, sp_we, sp_wdat, flg_clr,
        input  tos, sp, stkful, stkunf, serr_rst, busy
    );

    modport slave (
        input  push, push_dat, pop, tos_we, tos_wdat, sp_we, sp_wdat, flg_clr,
        output tos, sp, stkful, stkunf, serr_rst, busy
    );
endinterface

// File: rtl/ae18_sram.sv
// Single-port-write, single-port-read stack RAM with registered, write-first read.
module ae18_sram #(
    parameter int ISIZ = 21,
    parameter int SSIZ = 5
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [SSIZ-1:0] wadr_i,
    input  logic [ISIZ-1:0] wdat_i,
    input  logic [SSIZ-1:0] radr_i,
    output logic [ISIZ-1:0] rdat_o
);
    logic [ISIZ-1:0] mem_q [2**SSIZ];
    logic [ISIZ-1:0] rdat_q;

    // Same-cycle write to the read address returns the new word.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wadr_i] <= wdat_i;
        rdat_q <= (we_i && (wadr_i == radr_i)) ? wdat_i : mem_q[radr_i];
    end

    assign rdat_o = rdat_q;
endmodule

// File: rtl/ae18_stack_ctl.sv
// AE18 hardware call stack: clears its RAM after reset, then services
// push/pop/TOS-write/pointer-load with sticky overflow/underflow flags.
module ae18_stack_ctl
    import ae18_pkg::*;
#(
    parameter int DW     = 21,
    parameter int AW     = 5,
    parameter bit STVREN = 1'b1
) (
    input logic             clk,
    input logic             rst,
    ae18_stack_ctl_if.slave bus
);
    localparam logic [AW-1:0] SP_MAX = AW'(stk_max(AW));

    stk_state_e    state_q, state_d;
    logic [AW-1:0] wadr_q, wadr_d;
    logic [AW-1:0] sp_q, sp_d;
    logic          ful_q, ful_d;
    logic          unf_q, unf_d;
    logic          serr_q, serr_d;
    logic          ovf_ev, unf_ev;

    logic          ram_we;
    logic [AW-1:0] ram_wadr;
    logic [DW-1:0] ram_wdat;
    logic [DW-1:0] ram_rdat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            wadr_q  <= '0;
            sp_q    <= '0;
            ful_q   <= 1'b0;
            unf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wadr_q  <= wadr_d;
            sp_q    <= sp_d;
            ful_q   <= ful_d;
            unf_q   <= unf_d;
            serr_q  <= serr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wadr_d   = wadr_q;
        sp_d     = sp_q;
        ful_d    = ful_q;
        unf_d    = unf_q;
        ovf_ev   = 1'b0;
        unf_ev   = 1'b0;
        ram_we   = 1'b0;
        ram_wadr = sp_q;
        ram_wdat = '0;

        case (state_q)
            ST_INIT: begin
                // Requests are dropped; the sequencer owns the write port.
                ram_we   = 1'b1;
                ram_wadr = wadr_q;
                wadr_d   = wadr_q + AW'(1);
                if (wadr_q == SP_MAX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.sp_we) begin
                    sp_d = bus.sp_wdat;
                end else if (bus.push && bus.pop) begin
                    if (sp_q == '0) begin
                        unf_ev = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        ram_wdat = bus.push_dat;
                    end
                end else if (bus.push) begin
                    if (sp_q == SP_MAX) begin
                        ovf_ev = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        ram_wadr = sp_q + AW'(1);
                        ram_wdat = bus.push_dat;
                        sp_d     = sp_q + AW'(1);
                    end
                end else if (bus.pop) begin
                    if (sp_q == '0) unf_ev = 1'b1;
                    else            sp_d   = sp_q - AW'(1);
                end else if (bus.tos_we) begin
                    if (sp_q != '0) begin
                        ram_we   = 1'b1;
                        ram_wdat = bus.tos_wdat;
                    end
                end

                if (bus.flg_clr) begin
                    ful_d = 1'b0;
                    unf_d = 1'b0;
                end
                if (ovf_ev) ful_d = 1'b1;
                if (unf_ev) unf_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase

        serr_d = STVREN && (ovf_ev || unf_ev);
    end

    // Reading at next-sp lets tos track the pointer with no extra cycle.
    ae18_sram #(
        .ISIZ(DW),
        .SSIZ(AW)
    ) u_sram (
        .clk   (clk),
        .we_i  (ram_we),
        .wadr_i(ram_wadr),
        .wdat_i(ram_wdat),
        .radr_i(sp_d),
        .rdat_o(ram_rdat)
    );

    assign bus.tos      = (sp_q == '0) ? '0 : ram_rdat;
    assign bus.sp       = sp_q;
    assign bus.stkful   = ful_q;
    assign bus.stkunf   = unf_q;
    assign bus.serr_rst = serr_q;
    assign bus.busy     = (state_q == ST_INIT);
endmodule
